// File: rtl/cache_miss_controller.sv
// Direct-mapped D-cache miss sequencer: zero-latency load hits, word-by-word line refill, write-through stores.
// Define WRITE_ALLOCATE_EN to refill the line on a store miss before the write-through (default: write-no-allocate).
module cache_miss_controller #(
   parameter int ADDR_W   = 10,
   parameter int OFFSET_W = 2
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                MemRead,
   input  logic                MemWrite,
   input  logic [ADDR_W-1:0]   WordAddress,
   input  logic                Hit,
   input  logic                mem_ack,
   output logic                stall,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                fill_we,
   output logic [OFFSET_W-1:0] fill_idx,
   output logic                line_we,
   output logic                cache_we
);

   typedef enum logic [1:0] {IDLE, REFILL, WRITE_THRU, DONE} state_t;

   localparam logic [OFFSET_W-1:0] LAST_WORD = {OFFSET_W{1'b1}};

   state_t              state_q, state_d;
   logic [OFFSET_W-1:0] cnt_q, cnt_d;
   logic                wr_hit_q, wr_hit_d;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         wr_hit_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wr_hit_q <= wr_hit_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_hit_d = wr_hit_q;
      stall    = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      fill_we  = 1'b0;
      fill_idx = '0;
      line_we  = 1'b0;
      cache_we = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Store takes priority over load when both strobes are high
            if (MemWrite) begin
               stall    = 1'b1;
               wr_hit_d = Hit;
               cnt_d    = '0;
`ifdef WRITE_ALLOCATE_EN
               state_d  = Hit ? WRITE_THRU : REFILL;
`else
               state_d  = WRITE_THRU;
`endif
            end else if (MemRead && !Hit) begin
               stall   = 1'b1;
               cnt_d   = '0;
               state_d = REFILL;
            end
         end

         REFILL: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = {WordAddress[ADDR_W-1:OFFSET_W], cnt_q};
            fill_idx = cnt_q;
            if (mem_ack) begin
               fill_we = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == LAST_WORD) begin
                  line_we = 1'b1;
                  // An allocating store continues to the write-through with the line now resident
                  if (MemWrite) begin
                     wr_hit_d = 1'b1;
                     state_d  = WRITE_THRU;
                  end else begin
                     state_d  = DONE;
                  end
               end
            end
         end

         WRITE_THRU: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = WordAddress;
            if (mem_ack) state_d = DONE;
         end

         DONE: begin
            cache_we = MemWrite && wr_hit_q;
            state_d  = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

endmodule
